rx_cmd_seq: RTL and testbench

- Command sequencer directly upstream of the remote-IO host serializer.
- Accepts register read/write requests over a valid/ready handshake and issues at most one command per 512-cycle serial frame, so a second write cannot overwrite a command still waiting in the serializer's buffer.
- Returns one response per request: read data, write completion, or timeout.
- Also forwards sample-delay configuration writes, which are local to the serializer and not frame-paced.

---
 rtl/rx_cmd_seq.sv | 155 +++++++++++++++
 tb/tb_rx_cmd_seq.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_cmd_seq.sv
// Frame-paced register command sequencer feeding the remote-IO host serializer.
// One read/write is in flight at a time. Sample-delay config writes bypass frame pacing.
`timescale 1ns/1ps
module rx_cmd_seq #(
    parameter int FRAME_CYCLES   = 512,
    parameter int TIMEOUT_CYCLES = 1100,
    parameter int CNT_W          = 11
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic [3:0]  req_addr,
    input  logic [15:0] req_wdata,
    input  logic        cfg_valid,
    input  logic [2:0]  cfg_delay,
    output logic        wvalid,
    output logic [20:0] wdata,
    output logic        addr,
    input  logic        rvalid,
    input  logic [63:0] rdata,
    output logic        resp_valid,
    output logic [15:0] resp_data,
    output logic        resp_timeout
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_WR, WAIT_RD, RESP} state_t;

    localparam logic [CNT_W-1:0] FRAME_LAST   = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_d;
    logic             cmd_read;
    logic             cfg_pending;
    logic             cfg_pending_d;
    logic [2:0]       cfg_latched;
    logic [2:0]       cfg_latched_d;
    logic             accept;

    logic             wvalid_d;
    logic [20:0]      wdata_d;
    logic             addr_d;
    logic             resp_valid_d;
    logic [15:0]      resp_data_d;
    logic             resp_timeout_d;

    logic             unused_rdata_hi;
    assign unused_rdata_hi = ^rdata[63:16];

    // A pending or arriving config write always wins the serializer slot over a request.
    assign req_ready = reset_n && (state == IDLE) && !cfg_pending && !cfg_valid;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ISSUE;
            ISSUE:   next_state = cmd_read ? WAIT_RD : WAIT_WR;
            WAIT_WR: if (count == FRAME_LAST) next_state = RESP;
            WAIT_RD: if (rvalid || (count == TIMEOUT_LAST)) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Counter runs from 0 in the issue cycle, so it measures clocks since the command went out.
    always_comb begin
        count_d = '0;
        if (!accept && ((state == ISSUE) || (state == WAIT_WR) || (state == WAIT_RD))) begin
            count_d = count + CNT_W'(1);
        end
    end

    always_comb begin
        cfg_pending_d = cfg_pending;
        cfg_latched_d = cfg_latched;
        if ((state == IDLE) && cfg_pending) begin
            cfg_pending_d = 1'b0;
        end
        if (cfg_valid) begin
            cfg_pending_d = 1'b1;
            cfg_latched_d = cfg_delay;
        end
    end

    // Outputs are computed from next-cycle values so the registered strobe lines up with its state.
    always_comb begin
        wvalid_d       = 1'b0;
        wdata_d        = '0;
        addr_d         = 1'b0;
        resp_valid_d   = 1'b0;
        resp_data_d    = '0;
        resp_timeout_d = 1'b0;
        if (accept) begin
            wvalid_d = 1'b1;
            wdata_d  = {req_read, req_addr, req_wdata};
        end else if ((next_state == IDLE) && cfg_pending_d) begin
            wvalid_d = 1'b1;
            addr_d   = 1'b1;
            wdata_d  = {18'b0, cfg_latched_d};
        end
        if ((state == WAIT_WR) && (next_state == RESP)) begin
            resp_valid_d = 1'b1;
        end
        if ((state == WAIT_RD) && (next_state == RESP)) begin
            resp_valid_d = 1'b1;
            if (rvalid) begin
                resp_data_d = rdata[15:0];
            end else begin
                resp_timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count        <= '0;
            cmd_read     <= 1'b0;
            cfg_pending  <= 1'b0;
            cfg_latched  <= '0;
            wvalid       <= 1'b0;
            wdata        <= '0;
            addr         <= 1'b0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_timeout <= 1'b0;
        end else begin
            count        <= count_d;
            if (accept) begin
                cmd_read <= req_read;
            end
            cfg_pending  <= cfg_pending_d;
            cfg_latched  <= cfg_latched_d;
            wvalid       <= wvalid_d;
            wdata        <= wdata_d;
            addr         <= addr_d;
            resp_valid   <= resp_valid_d;
            resp_data    <= resp_data_d;
            resp_timeout <= resp_timeout_d;
        end
    end

endmodule

// File: tb/tb_rx_cmd_seq.sv
// Directed self-checking bench for rx_cmd_seq: write/read/timeout paths, frame pacing,
// config forwarding, stray read returns and mid-transaction reset.
`timescale 1ns/1ps
module tb_rx_cmd_seq;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_read;
    logic [3:0]  req_addr;
    logic [15:0] req_wdata;
    logic        cfg_valid;
    logic [2:0]  cfg_delay;
    logic        wvalid;
    logic [20:0] wdata;
    logic        addr;
    logic        rvalid;
    logic [63:0] rdata;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        resp_timeout;

    int errors = 0;
    int checks = 0;

    always #4 clock = ~clock;

    rx_cmd_seq dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_read     (req_read),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .cfg_valid    (cfg_valid),
        .cfg_delay    (cfg_delay),
        .wvalid       (wvalid),
        .wdata        (wdata),
        .addr         (addr),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_timeout (resp_timeout)
    );

    // Advance to 2 ns after the next rising edge: registered outputs are settled, inputs are driven here.
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0;
        req_read  = 1'b0;
        req_addr  = 4'h0;
        req_wdata = 16'h0;
        cfg_valid = 1'b0;
        cfg_delay = 3'd0;
        rvalid    = 1'b0;
        rdata     = 64'h0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        req_valid = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_req_ready: got %b expected 0", req_ready);
        end
        checks++;
        if ({wvalid, addr, wdata, resp_valid, resp_timeout, resp_data} !== 40'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {wvalid, addr, wdata, resp_valid, resp_timeout, resp_data});
        end
        req_valid = 1'b0;
        reset_n   = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release_req_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_write();
        int bad;
        bad = 0;
        step();
        req_valid = 1'b1; req_read = 1'b0; req_addr = 4'h3; req_wdata = 16'hBEEF;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_accept_ready: got %b expected 1", req_ready);
        end
        step();
        idle_inputs();
        checks++;
        if ({wvalid, addr, wdata} !== {1'b1, 1'b0, 21'h03BEEF}) begin
            errors++;
            $display("[TB] FAIL write_issue: got wvalid=%b addr=%b wdata=%h expected 1 0 03beef",
                     wvalid, addr, wdata);
        end
        for (int k = 2; k <= 512; k++) begin
            step();
            if (wvalid !== 1'b0 || resp_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL write_quiet_frame: got %0d busy cycles expected 0", bad);
        end
        step();
        checks++;
        if ({resp_valid, resp_timeout, resp_data} !== {1'b1, 1'b0, 16'h0}) begin
            errors++;
            $display("[TB] FAIL write_resp: got valid=%b timeout=%b data=%h expected 1 0 0000",
                     resp_valid, resp_timeout, resp_data);
        end
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_ready_in_resp: got %b expected 0", req_ready);
        end
        step();
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_ready_after: got ready=%b resp_valid=%b expected 1 0",
                     req_ready, resp_valid);
        end
    endtask

    task automatic test_read();
        int bad;
        bad = 0;
        step();
        req_valid = 1'b1; req_read = 1'b1; req_addr = 4'hA; req_wdata = 16'h0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL read_accept_ready: got %b expected 1", req_ready);
        end
        step();
        idle_inputs();
        checks++;
        if ({wvalid, addr, wdata} !== {1'b1, 1'b0, 21'h1A0000}) begin
            errors++;
            $display("[TB] FAIL read_issue: got wvalid=%b addr=%b wdata=%h expected 1 0 1a0000",
                     wvalid, addr, wdata);
        end
        for (int k = 2; k <= 700; k++) begin
            step();
            if (resp_valid !== 1'b0 || wvalid !== 1'b0) bad++;
        end
        rvalid = 1'b1;
        rdata  = 64'hDEAD_BEEF_0000_1234;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL read_quiet: got %0d busy cycles expected 0", bad);
        end
        step();
        idle_inputs();
        checks++;
        if ({resp_valid, resp_timeout, resp_data} !== {1'b1, 1'b0, 16'h1234}) begin
            errors++;
            $display("[TB] FAIL read_resp: got valid=%b timeout=%b data=%h expected 1 0 1234",
                     resp_valid, resp_timeout, resp_data);
        end
        step();
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_ready_after: got ready=%b resp_valid=%b expected 1 0",
                     req_ready, resp_valid);
        end
    endtask

    task automatic test_read_timeout();
        int          bad;
        logic [17:0] exp_resp;
        for (int late = 0; late < 2; late++) begin
            bad = 0;
            exp_resp = (late == 1) ? {1'b1, 1'b0, 16'hABCD} : {1'b1, 1'b1, 16'h0};
            step();
            req_valid = 1'b1; req_read = 1'b1; req_addr = 4'h5; req_wdata = 16'h0;
            step();
            idle_inputs();
            for (int k = 2; k <= 1100; k++) begin
                step();
                if (resp_valid !== 1'b0) bad++;
            end
            if (late == 1) begin
                rvalid = 1'b1;
                rdata  = 64'h0000_0000_0000_ABCD;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("[TB] FAIL timeout_quiet_%0d: got %0d early responses expected 0", late, bad);
            end
            step();
            idle_inputs();
            checks++;
            if ({resp_valid, resp_timeout, resp_data} !== exp_resp) begin
                errors++;
                $display("[TB] FAIL timeout_resp_%0d: got %h expected %h", late,
                         {resp_valid, resp_timeout, resp_data}, exp_resp);
            end
            step();
            #1;
            checks++;
            if (req_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL timeout_ready_%0d: got %b expected 1", late, req_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          strobe_at[$];
        logic [20:0] strobe_data[$];
        int          accepted;
        int          resps;
        int          adjacent;
        logic        prev_wv;
        logic [20:0] exp_data;
        accepted = 0; resps = 0; adjacent = 0; prev_wv = 1'b0;
        step();
        req_valid = 1'b1; req_read = 1'b0; req_addr = 4'h7; req_wdata = 16'h1000;
        for (int k = 0; k <= 1545; k++) begin
            if (k > 0) step();
            if (wvalid === 1'b1) begin
                if (prev_wv) adjacent++;
                strobe_at.push_back(k);
                strobe_data.push_back(wdata);
            end
            prev_wv = (wvalid === 1'b1);
            if (resp_valid === 1'b1) resps++;
            if (accepted >= 3) req_valid = 1'b0;
            else req_wdata = 16'h1000 + 16'(accepted);
            #1;
            if (req_valid === 1'b1 && req_ready === 1'b1) accepted++;
        end
        idle_inputs();
        checks++;
        if (strobe_at.size() != 3) begin
            errors++;
            $display("[TB] FAIL b2b_strobe_count: got %0d expected 3", strobe_at.size());
        end
        for (int i = 1; i < strobe_at.size(); i++) begin
            checks++;
            if (strobe_at[i] - strobe_at[i-1] != 514) begin
                errors++;
                $display("[TB] FAIL b2b_spacing_%0d: got %0d expected 514", i,
                         strobe_at[i] - strobe_at[i-1]);
            end
        end
        for (int i = 0; i < strobe_data.size() && i < 3; i++) begin
            exp_data = {1'b0, 4'h7, 16'h1000 + 16'(i)};
            checks++;
            if (strobe_data[i] !== exp_data) begin
                errors++;
                $display("[TB] FAIL b2b_data_%0d: got %h expected %h", i, strobe_data[i], exp_data);
            end
        end
        checks++;
        if (accepted != 3 || resps != 3 || adjacent != 0) begin
            errors++;
            $display("[TB] FAIL b2b_counts: got accepted=%0d resps=%0d adjacent=%0d expected 3 3 0",
                     accepted, resps, adjacent);
        end
    endtask

    task automatic test_cfg();
        int bad;
        int got_at;
        bad = 0; got_at = -1;
        step();
        req_valid = 1'b1; req_read = 1'b0; req_addr = 4'h2; req_wdata = 16'h0055;
        step();
        idle_inputs();
        for (int k = 2; k <= 512; k++) begin
            step();
            if (k == 10) begin cfg_valid = 1'b1; cfg_delay = 3'd5; end
            if (k == 11) begin cfg_valid = 1'b1; cfg_delay = 3'd2; end
            if (k == 12) cfg_valid = 1'b0;
            if (wvalid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL cfg_held_in_frame: got %0d strobes expected 0", bad);
        end
        step();
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cfg_frame_resp: got %b expected 1", resp_valid);
        end
        step();
        req_valid = 1'b1; req_read = 1'b0; req_addr = 4'hC; req_wdata = 16'h0042;
        checks++;
        if ({wvalid, addr, wdata} !== {1'b1, 1'b1, 21'd2}) begin
            errors++;
            $display("[TB] FAIL cfg_strobe: got wvalid=%b addr=%b wdata=%h expected 1 1 000002",
                     wvalid, addr, wdata);
        end
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cfg_blocks_req: got %b expected 0", req_ready);
        end
        step();
        checks++;
        if (wvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cfg_single_strobe: got %b expected 0", wvalid);
        end
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cfg_req_late_ready: got %b expected 1", req_ready);
        end
        step();
        idle_inputs();
        checks++;
        if ({wvalid, addr, wdata} !== {1'b1, 1'b0, 21'h0C0042}) begin
            errors++;
            $display("[TB] FAIL cfg_req_issue: got wvalid=%b addr=%b wdata=%h expected 1 0 0c0042",
                     wvalid, addr, wdata);
        end
        for (int k = 517; k <= 1030; k++) begin
            step();
            if (resp_valid === 1'b1 && got_at < 0) got_at = k;
        end
        checks++;
        if (got_at != 1028) begin
            errors++;
            $display("[TB] FAIL cfg_req_resp_cycle: got %0d expected 1028", got_at);
        end
        // Config arriving in IDLE: strobe next cycle, request held off until it has gone out.
        cfg_valid = 1'b1; cfg_delay = 3'd7; req_valid = 1'b1; req_addr = 4'h1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cfg_idle_ready: got %b expected 0", req_ready);
        end
        step();
        cfg_valid = 1'b0;
        req_valid = 1'b0;
        checks++;
        if ({wvalid, addr, wdata} !== {1'b1, 1'b1, 21'd7}) begin
            errors++;
            $display("[TB] FAIL cfg_idle_strobe: got wvalid=%b addr=%b wdata=%h expected 1 1 000007",
                     wvalid, addr, wdata);
        end
        step();
        #1;
        checks++;
        if (req_ready !== 1'b1 || wvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cfg_idle_done: got ready=%b wvalid=%b expected 1 0", req_ready, wvalid);
        end
    endtask

    task automatic test_stray_rvalid();
        int bad;
        bad = 0;
        step();
        rvalid = 1'b1;
        rdata  = 64'h5555;
        step();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            if (resp_valid !== 1'b0 || wvalid !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL stray_rvalid_resp: got %0d active cycles expected 0", bad);
        end
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stray_rvalid_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        step();
        req_valid = 1'b1; req_read = 1'b1; req_addr = 4'h1;
        step();
        idle_inputs();
        checks++;
        if (wvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_issue_strobe: got %b expected 1", wvalid);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({wvalid, addr, wdata, resp_valid, resp_timeout, resp_data, req_ready} !== 41'h0) begin
            errors++;
            $display("[TB] FAIL rst_issue_clear: got %h expected 0",
                     {wvalid, addr, wdata, resp_valid, resp_timeout, resp_data, req_ready});
        end
        step();
        reset_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_issue_release: got %b expected 1", req_ready);
        end
        step();
        req_valid = 1'b1; req_read = 1'b1; req_addr = 4'h9;
        step();
        idle_inputs();
        for (int k = 2; k <= 50; k++) begin
            step();
            if (k == 40) begin cfg_valid = 1'b1; cfg_delay = 3'd6; end
            if (k == 41) cfg_valid = 1'b0;
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({wvalid, addr, wdata, resp_valid, resp_timeout, resp_data, req_ready} !== 41'h0) begin
            errors++;
            $display("[TB] FAIL rst_wait_clear: got %h expected 0",
                     {wvalid, addr, wdata, resp_valid, resp_timeout, resp_data, req_ready});
        end
        step();
        reset_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_wait_release: got %b expected 1", req_ready);
        end
        for (int k = 0; k < 1200; k++) begin
            step();
            if (resp_valid !== 1'b0 || wvalid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL rst_no_response: got %0d active cycles expected 0", bad);
        end
    endtask

    initial begin
        $display("[TB] rx_cmd_seq directed tests starting");
        test_reset();
        test_write();
        test_read();
        test_read_timeout();
        test_back_to_back();
        test_cfg();
        test_stray_rvalid();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
